// File: rtl/memory_address_register_core.sv
// SAP-1 memory address register: latches the W-bus address on MI in run mode,
// or follows the front-panel switches every clock in program mode.
module memory_address_register_core #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEBUG      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [ADDR_WIDTH-1:0] o_address,
  input  logic                  i_prog,
  input  logic [ADDR_WIDTH-1:0] i_manual_address
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_next_s;

  // Next-address select; a control at X/Z matches no branch and holds.
  always_comb begin
    addr_next_s = addr_r;
    if (i_prog === 1'b1) begin
      addr_next_s = i_manual_address;
    end else if ((i_prog === 1'b0) && (i_load === 1'b1)) begin
      addr_next_s = i_address;
    end else begin
      addr_next_s = addr_r;
    end
  end

  // Address register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      addr_r <= addr_next_s;
    end
  end

  assign o_address = addr_r;

  generate
    if (DEBUG != 0) begin : g_trace
      // Simulation-only trace of every stored-value change.
      always_ff @(posedge clk) begin
        if (!reset && (addr_next_s != addr_r)) begin
          $display("[%0t] mar %b -> %b", $time, addr_r, addr_next_s);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_memory_address_register_core.sv
// Directed-vector bench for memory_address_register_core with hand-computed
// expected addresses.
module tb_memory_address_register_core;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset;
  logic          i_load;
  logic [AW-1:0] i_address;
  logic [AW-1:0] o_address;
  logic          i_prog;
  logic [AW-1:0] i_manual_address;

  int tests_run;
  int tests_failed;

  memory_address_register_core #(
    .ADDR_WIDTH(AW),
    .DEBUG     (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_load          (i_load),
    .i_address       (i_address),
    .o_address       (o_address),
    .i_prog          (i_prog),
    .i_manual_address(i_manual_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [AW-1:0] obs,
                           input logic [AW-1:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    i_load           = 1'b0;
    i_prog           = 1'b0;
    i_address        = 4'b0000;
    i_manual_address = 4'b0000;
    #2;
    check_val("reset_initial", o_address, 4'b0000);
    tick();
    check_val("reset_held_edge", o_address, 4'b0000);
    reset = 1'b0;

    // Put 1011 in, then clear it asynchronously mid-cycle.
    i_address = 4'b1011;
    i_load    = 1'b1;
    tick();
    check_val("load_1011", o_address, 4'b1011);
    i_load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset", o_address, 4'b0000);
    #1;
    reset = 1'b0;
    tick();
    check_val("after_release", o_address, 4'b0000);

    // No strobe: address changes are ignored.
    i_address = 4'b1010;
    tick();
    tick();
    check_val("no_strobe", o_address, 4'b0000);

    // Strobed load, then hold against a new bus value.
    i_address = 4'b0110;
    i_load    = 1'b1;
    tick();
    check_val("strobe_0110", o_address, 4'b0110);
    i_load    = 1'b0;
    i_address = 4'b1111;
    tick();
    check_val("hold_0110_a", o_address, 4'b0110);
    tick();
    check_val("hold_0110_b", o_address, 4'b0110);

    // All-ones, all-zeros, back-to-back loads.
    i_load    = 1'b1;
    i_address = 4'b1111;
    tick();
    check_val("load_ones", o_address, 4'b1111);
    i_address = 4'b0000;
    tick();
    check_val("load_zeros", o_address, 4'b0000);
    i_address = 4'b0011;
    tick();
    check_val("b2b_first", o_address, 4'b0011);
    i_address = 4'b1100;
    tick();
    check_val("b2b_last", o_address, 4'b1100);

    // Program mode overrides load/address.
    i_prog           = 1'b1;
    i_manual_address = 4'b0101;
    i_address        = 4'b1001;
    i_load           = 1'b1;
    #1;
    check_val("prog_no_edge_yet", o_address, 4'b1100);
    tick();
    check_val("prog_capture", o_address, 4'b0101);
    i_manual_address = 4'b1110;
    #2;
    check_val("prog_between_edges", o_address, 4'b0101);
    tick();
    check_val("prog_follow", o_address, 4'b1110);
    i_manual_address = 4'b0101;
    tick();
    check_val("prog_back_0101", o_address, 4'b0101);
    i_prog           = 1'b0;
    i_load           = 1'b0;
    i_manual_address = 4'b0010;
    tick();
    check_val("run_hold_0101", o_address, 4'b0101);

    // Reset wins over a load in progress, in both modes.
    i_address = 4'b0111;
    i_load    = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_val("reset_mid_load", o_address, 4'b0000);
    tick();
    check_val("reset_blocks_load", o_address, 4'b0000);
    i_prog = 1'b1;
    tick();
    check_val("reset_blocks_prog", o_address, 4'b0000);
    reset  = 1'b0;
    i_prog = 1'b0;
    i_load = 1'b0;
    tick();
    check_val("post_reset_hold", o_address, 4'b0000);
    i_load = 1'b1;
    tick();
    check_val("post_reset_load", o_address, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
